irq_arbiter: RTL and testbench

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter.sv | 145 ++++++++++++++
 tb/tb_irq_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: synchronizes raw IRQ lines, latches pending
// events (edge or level per source) and hands the lowest enabled one to the controller.
module irq_arbiter #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src_i,
    output logic [7:0]       irq_req_addr_o,
    input  logic             irq_ack_i,
    input  logic             irq_exit_i,
    output logic             in_service_o,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [31:0]      cfg_wdata_i,
    output logic [31:0]      cfg_rdata_o
);

    // state | meaning
    // IDLE  | no claim, arbitrate among pending & enabled sources
    // REQ   | cur_id presented to controller, waiting for ack
    // SERVE | handler running, waiting for exit pulse
    typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

    localparam int W = (N_SRC < 32) ? N_SRC : 32;

    state_t           state, state_n;
    logic [N_SRC-1:0] sync1, sync2, prev;
    logic [N_SRC-1:0] pending, pending_n, enable, mode;
    logic [N_SRC-1:0] set_evt, eligible, wvec;
    logic [7:0]       cur_id, cur_id_n, win_id;
    logic             any_elig, cur_wbit, ack_clr;
    logic             we_en, we_pend, we_mode;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata_i;

    assign we_en   = cfg_we_i && (cfg_addr_i == 2'd0);
    assign we_pend = cfg_we_i && (cfg_addr_i == 2'd1);
    assign we_mode = cfg_we_i && (cfg_addr_i == 2'd3);

    always_comb begin
        wvec = '0;
        wvec[W-1:0] = cfg_wdata_i[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= irq_src_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign set_evt  = (sync2 & ~prev & ~mode) | (sync2 & mode);
    assign eligible = pending & enable;
    assign any_elig = |eligible;

    // Scan downward so the lowest eligible index is the last one assigned.
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win_id = 8'(i);
        end
    end

    always_comb begin
        cur_wbit = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (8'(i) == cur_id) cur_wbit = wvec[i];
        end
    end

    always_comb begin
        state_n  = state;
        cur_id_n = cur_id;
        ack_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    cur_id_n = win_id;
                    state_n  = REQ;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    ack_clr = 1'b1;
                    state_n = SERVE;
                end else if (we_en && !cur_wbit) begin
                    state_n = IDLE;
                end
            end
            SERVE: begin
                if (irq_exit_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Set events are OR'd in last so they win over any same-cycle clear.
    always_comb begin
        pending_n = pending;
        if (we_pend) pending_n = pending_n & ~wvec;
        if (ack_clr) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (8'(i) == cur_id) pending_n[i] = 1'b0;
            end
        end
        pending_n = pending_n | set_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_id  <= '0;
            pending <= '0;
            enable  <= '0;
            mode    <= '0;
        end else begin
            state   <= state_n;
            cur_id  <= cur_id_n;
            pending <= pending_n;
            if (we_en)   enable <= wvec;
            if (we_mode) mode   <= wvec;
        end
    end

    assign irq_req_addr_o = (state == REQ) ? 8'(cur_id + 8'd1) : 8'd0;
    assign in_service_o   = (state == SERVE);

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            2'd0: cfg_rdata_o[W-1:0] = enable[W-1:0];
            2'd1: cfg_rdata_o[W-1:0] = pending[W-1:0];
            2'd2: if (state == SERVE) cfg_rdata_o[7:0] = 8'(cur_id + 8'd1);
            default: cfg_rdata_o[W-1:0] = mode[W-1:0];
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter; each new request presented by the DUT is
// compared by a monitor against an expected-request queue.
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_src_i;
    logic [7:0]  irq_req_addr_o;
    logic        irq_ack_i;
    logic        irq_exit_i;
    logic        in_service_o;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic [7:0] prev_addr = 8'd0;

    irq_arbiter #(.N_SRC(8)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src_i(irq_src_i),
        .irq_req_addr_o(irq_req_addr_o), .irq_ack_i(irq_ack_i),
        .irq_exit_i(irq_exit_i), .in_service_o(in_service_o),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o)
    );

    always #5 clk = ~clk;

    // Monitor: every fresh request (0 -> nonzero) pops one expected address.
    always @(negedge clk) begin
        if (rst_n && irq_req_addr_o != 8'd0 && prev_addr == 8'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_req: got %0d, expected none", irq_req_addr_o);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(irq_req_addr_o) != e) begin
                    errors++;
                    $display("FAIL sb_req: got %0d, expected %0d", irq_req_addr_o, e);
                end
            end
        end
        prev_addr = rst_n ? irq_req_addr_o : 8'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        cyc(1);
        cfg_we_i = 1'b0; cfg_wdata_i = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr_i = a;
        #1;
        d = cfg_rdata_o;
    endtask

    task automatic ack();
        irq_ack_i = 1'b1; cyc(1); irq_ack_i = 1'b0;
    endtask

    task automatic do_exit();
        irq_exit_i = 1'b1; cyc(1); irq_exit_i = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (irq_req_addr_o == 8'd0 && k < 50) begin
            cyc(1);
            k++;
        end
        if (irq_req_addr_o == 8'd0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for request, got 0, expected nonzero", name);
        end
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; irq_src_i = '0; irq_ack_i = 0; irq_exit_i = 0;
        cfg_we_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
        cyc(3);
        check("rst_req", irq_req_addr_o, 0);
        check("rst_insvc", in_service_o, 0);
        rst_n = 1'b1;
        cyc(2);
        rd(2'd0, r); check("rst_enable", r, 0);
        rd(2'd1, r); check("rst_pending", r, 0);
        rd(2'd3, r); check("rst_mode", r, 0);

        // Single edge source, latency and service cycle
        cfg_wr(2'd0, 32'hFF);
        rd(2'd0, r); check("enable_rb", r, 32'hFF);
        exp_q.push_back(4);
        @(negedge clk); irq_src_i = 8'h08;     // first sampled at next rising edge T0
        cyc(2);                                // now just after T0+1
        rd(2'd1, r); check("lat_pend_t1", r, 0);
        cyc(1);
        rd(2'd1, r); check("lat_pend_t2", r, 32'h08);
        check("lat_req_t2", irq_req_addr_o, 0);
        cyc(1);
        check("lat_req_t3", irq_req_addr_o, 4);
        irq_src_i = '0;
        ack();
        check("ack_req0", irq_req_addr_o, 0);
        check("ack_insvc", in_service_o, 1);
        rd(2'd2, r); check("claim_id", r, 4);
        rd(2'd1, r); check("ack_pend_clr", r, 0);
        cyc(3);
        check("serve_no_req", irq_req_addr_o, 0);
        do_exit();
        check("exit_insvc", in_service_o, 0);
        rd(2'd2, r); check("claim_idle", r, 0);

        // Simultaneous sources 5 and 2
        exp_q.push_back(3); exp_q.push_back(6);
        irq_src_i = 8'h24;
        wait_req("prio_a");
        check("prio_first", irq_req_addr_o, 3);
        irq_src_i = '0;
        ack(); do_exit();
        wait_req("prio_b");
        check("prio_second", irq_req_addr_o, 6);

        // No re-arbitration while request 6 is outstanding
        irq_src_i = 8'h01;
        cyc(6);
        check("no_rearb", irq_req_addr_o, 6);
        rd(2'd1, r); check("no_rearb_pend", r, 32'h21);
        irq_src_i = '0;
        exp_q.push_back(1);
        ack(); do_exit();
        wait_req("after_rearb");
        check("after_rearb_req", irq_req_addr_o, 1);
        ack(); do_exit();

        // Level mode reissue
        cfg_wr(2'd3, 32'h02);
        rd(2'd3, r); check("mode_rb", r, 32'h02);
        exp_q.push_back(2); exp_q.push_back(2);
        irq_src_i = 8'h02;
        wait_req("lvl_a");
        ack();
        rd(2'd1, r); check("lvl_set_wins", r, 32'h02);
        do_exit();
        wait_req("lvl_b");
        check("lvl_reissue", irq_req_addr_o, 2);
        irq_src_i = '0;
        cyc(4);
        ack(); do_exit();
        cyc(2);
        rd(2'd1, r); check("lvl_pend_clr", r, 0);

        // Edge mode, same stimulus: no reissue
        cfg_wr(2'd3, 32'h00);
        exp_q.push_back(2);
        irq_src_i = 8'h02;
        wait_req("edge_a");
        ack(); do_exit();
        cyc(6);
        check("edge_no_reissue", irq_req_addr_o, 0);
        rd(2'd1, r); check("edge_pend", r, 0);
        irq_src_i = '0;

        // Withdraw on disable, reissue on re-enable
        exp_q.push_back(5);
        irq_src_i = 8'h10;
        wait_req("wd_a");
        check("wd_req", irq_req_addr_o, 5);
        irq_src_i = '0;
        cfg_wr(2'd0, 32'h00);
        check("wd_out0", irq_req_addr_o, 0);
        rd(2'd1, r); check("wd_pend_kept", r, 32'h10);
        cyc(3);
        check("wd_stays0", irq_req_addr_o, 0);
        exp_q.push_back(5);
        cfg_wr(2'd0, 32'hFF);
        wait_req("wd_b");
        check("wd_reissue", irq_req_addr_o, 5);
        ack(); do_exit();

        // W1C on PENDING while disabled
        cfg_wr(2'd0, 32'h00);
        irq_src_i = 8'h80;
        cyc(4);
        irq_src_i = '0;
        rd(2'd1, r); check("w1c_before", r, 32'h80);
        cfg_wr(2'd1, 32'h80);
        rd(2'd1, r); check("w1c_after", r, 0);
        cfg_wr(2'd0, 32'hFF);

        // Reset during SERVE
        exp_q.push_back(4);
        irq_src_i = 8'h08;
        wait_req("rst_a");
        irq_src_i = '0;
        ack();
        check("pre_rst_insvc", in_service_o, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_insvc", in_service_o, 0);
        check("async_rst_req", irq_req_addr_o, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        rd(2'd0, r); check("post_rst_enable", r, 0);
        rd(2'd1, r); check("post_rst_pending", r, 0);
        rd(2'd2, r); check("post_rst_claim", r, 0);
        rd(2'd3, r); check("post_rst_mode", r, 0);
        cyc(8);
        check("post_rst_req", irq_req_addr_o, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
